// File: rtl/output_writeback_dma_if.sv
// AXI4 write-channel bundle (AW, W, B) between the writeback DMA and DDR.
// The master modport is the DMA side; the slave modport is the memory side.
interface output_writeback_dma_if #(
  parameter int BW = 128
) ();
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [BW-1:0]   wdata;
  logic [BW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/output_writeback_dma.sv
// Output writeback DMA: streams rows of the output buffer to DDR as AXI4
// INCR write bursts. Each burst is one address phase, then data beats fed
// by a 2-entry prefetch FIFO, then a write response.
// Optional feature: define WRITEBACK_4K_SPLIT_EN to keep bursts from
// crossing a 4 KB boundary.
module output_writeback_dma #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 4,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int ADDR_WIDTH           = 10,
  parameter int MAX_BURST            = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        axi_master_start_pulse,
  input  logic [31:0]                 axi_master_dest_addr,
  input  logic [ADDR_WIDTH-1:0]       axi_master_src_addr,
  input  logic [15:0]                 axi_master_length,
  output logic                        axi_master_done_irq,
  output logic                        busy,
  output logic                        wb_error,
  output logic [ADDR_WIDTH-1:0]       axim_rd_addr_in,
  output logic                        axim_rd_en_in,
  input  logic [DATA_WIDTH_ACCUM-1:0] axim_rd_data_out [SYSTOLIC_ARRAY_WIDTH],
  output_writeback_dma_if.master      axi
);

  localparam int BW         = SYSTOLIC_ARRAY_WIDTH * DATA_WIDTH_ACCUM;
  localparam int BYTES      = BW / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                state, state_next;
  logic [31:0]           dest;
  logic [ADDR_WIDTH-1:0] src;
  logic [15:0]           remaining;
  logic [8:0]            burst_beats;
  logic [8:0]            issued;
  logic [8:0]            sent;
  logic [8:0]            beats_calc;
  logic [BW-1:0]         fifo_mem [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            fifo_count;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [BW-1:0]         rd_beat;
`ifdef WRITEBACK_4K_SPLIT_EN
  logic [12:0]           beats_4k;
`endif

  // Beats in the next burst: capped by rows left, MAX_BURST and optionally the 4 KB page
  always_comb begin
    beats_calc = (remaining > 16'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining);
`ifdef WRITEBACK_4K_SPLIT_EN
    beats_4k = (13'd4096 - {1'b0, dest[11:0]}) >> BYTE_SHIFT;
    if ({4'b0, beats_calc} > beats_4k) beats_calc = 9'(beats_4k);
`endif
  end

  // Flatten the buffer lanes into one beat, lane 0 in the low bits
  always_comb begin
    rd_beat = '0;
    for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++)
      rd_beat[i*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM] = axim_rd_data_out[i];
  end

  // Channel outputs, prefetch issue decision and next-state logic
  always_comb begin
    state_next          = state;
    axi.awvalid         = 1'b0;
    axi.bready          = 1'b0;
    axi_master_done_irq = 1'b0;
    busy                = (state == ADDR) || (state == DATA) || (state == RESP);
    axi.awaddr          = dest;
    axi.awlen           = (state == ADDR) ? 8'(beats_calc - 9'd1) : 8'd0;
    axi.awsize          = 3'(BYTE_SHIFT);
    axi.awburst         = 2'b01;
    axi.wstrb           = '1;
    axi.wvalid          = (state == DATA) && (fifo_count != 2'd0);
    axi.wdata           = axi.wvalid ? fifo_mem[rd_idx] : '0;
    axi.wlast           = axi.wvalid && (sent == burst_beats - 9'd1);
    pop                 = axi.wvalid && axi.wready;
    occupancy           = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    axim_rd_en_in       = (state == DATA) && (issued != burst_beats) && (occupancy < 3'd2);
    axim_rd_addr_in     = src + ADDR_WIDTH'(issued);

    case (state)
      IDLE: if (axi_master_start_pulse)
              state_next = (axi_master_length == 16'd0) ? DONE : ADDR;
      ADDR: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_next = DATA;
      end
      DATA: if (pop && axi.wlast) state_next = RESP;
      RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          if (axi.bresp != 2'b00)
            state_next = DONE;
          else if ((remaining - 16'(burst_beats)) != 16'd0)
            state_next = ADDR;
          else
            state_next = DONE;
        end
      end
      DONE: begin
        axi_master_done_irq = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job state: latch the request, track the current burst, advance after each OKAY response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dest        <= '0;
      src         <= '0;
      remaining   <= '0;
      burst_beats <= '0;
      issued      <= '0;
      sent        <= '0;
      wb_error    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (axi_master_start_pulse) begin
          dest      <= axi_master_dest_addr & ~32'(BYTES - 1);
          src       <= axi_master_src_addr;
          remaining <= axi_master_length;
          wb_error  <= 1'b0;
        end
        ADDR: if (axi.awready) begin
          burst_beats <= beats_calc;
          issued      <= '0;
          sent        <= '0;
        end
        DATA: begin
          if (axim_rd_en_in) issued <= issued + 9'd1;
          if (pop) sent <= sent + 9'd1;
        end
        RESP: if (axi.bvalid) begin
          if (axi.bresp != 2'b00) begin
            wb_error <= 1'b1;
          end else begin
            dest      <= dest + (32'(burst_beats) << BYTE_SHIFT);
            src       <= src + ADDR_WIDTH'(burst_beats);
            remaining <= remaining - 16'(burst_beats);
          end
        end
        default: ;
      endcase
    end
  end

  // Prefetch FIFO bookkeeping; a read's data lands the cycle after it issues
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight   <= 1'b0;
      wr_idx     <= 1'b0;
      rd_idx     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      inflight   <= axim_rd_en_in;
      if (inflight) wr_idx <= ~wr_idx;
      if (pop) rd_idx <= ~rd_idx;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // FIFO storage needs no reset since wdata is gated by wvalid
  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wr_idx] <= rd_beat;
  end

endmodule

// File: tb/tb_output_writeback_dma.sv
// Directed self-checking bench for output_writeback_dma.
// Each job is started, then a per-cycle loop drives the AXI slave handshakes
// and records every address, data and response handshake for checking.
module tb_output_writeback_dma;

  localparam int W  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = W * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   dest_addr = '0;
  logic [AW-1:0] src_addr = '0;
  logic [15:0]   length = '0;
  logic          done_irq;
  logic          busy;
  logic          wb_error;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data [W];

  output_writeback_dma_if #(.BW(BW)) axi_bus ();

  int compared = 0;
  int mismatched = 0;

  logic [31:0]   aw_addr_q [$];
  logic [7:0]    aw_len_q  [$];
  logic [BW-1:0] beat_q    [$];
  logic          last_q    [$];
  int b_cnt, irq_cnt, irq_cyc, b_cyc, overlap_cnt, rd_cnt;
  logic busy_at_irq;

  output_writeback_dma #(
    .SYSTOLIC_ARRAY_WIDTH(W), .DATA_WIDTH_ACCUM(DW), .ADDR_WIDTH(AW), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_master_start_pulse(start), .axi_master_dest_addr(dest_addr),
    .axi_master_src_addr(src_addr), .axi_master_length(length),
    .axi_master_done_irq(done_irq), .busy(busy), .wb_error(wb_error),
    .axim_rd_addr_in(rd_addr), .axim_rd_en_in(rd_en), .axim_rd_data_out(rd_data),
    .axi(axi_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rowLane(input logic [AW-1:0] row, input int lane);
    return 32'hC000_0000 | (32'(row) << 8) | 32'(lane);
  endfunction

  function automatic logic [BW-1:0] rowBeat(input int row);
    logic [BW-1:0] b;
    logic [AW-1:0] r;
    r = AW'(row);
    for (int i = 0; i < W; i++) b[i*DW +: DW] = rowLane(r, i);
    return b;
  endfunction

  // Output buffer model: registered read, one cycle latency
  always @(posedge clk) begin
    if (rd_en) for (int i = 0; i < W; i++) rd_data[i] <= rowLane(rd_addr, i);
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int src, input logic [31:0] dest, input int len);
    @(posedge clk); #1;
    src_addr = AW'(src);
    dest_addr = dest;
    length = 16'(len);
    axi_bus.awready = 1'b1;
    axi_bus.wready = 1'b1;
    axi_bus.bvalid = 1'b1;
    axi_bus.bresp = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_awvalid"}, axi_bus.awvalid, 0);
    checkOutput({tag, "_wvalid"}, axi_bus.wvalid, 0);
    checkOutput({tag, "_bready"}, axi_bus.bready, 0);
    checkOutput({tag, "_rd_en"}, rd_en, 0);
    checkOutput({tag, "_irq"}, done_irq, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wb_error"}, wb_error, 0);
    checkOutput({tag, "_awaddr"}, axi_bus.awaddr, 0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 0);
    checkOutput({tag, "_wdata"}, axi_bus.wdata, 0);
  endtask

  // Runs one job cycle by cycle; wpat selects the 1,0,0,1 wready pattern,
  // err_burst picks which response carries SLVERR, restart_cyc pulses a stray start.
  task automatic runJob(input int max_cyc, input bit wpat, input int err_burst, input int restart_cyc);
    int cyc;
    bit prev_stall;
    logic [BW-1:0] prev_data;
    logic prev_last;
    aw_addr_q.delete(); aw_len_q.delete(); beat_q.delete(); last_q.delete();
    b_cnt = 0; irq_cnt = 0; irq_cyc = -1; b_cyc = -1; overlap_cnt = 0; rd_cnt = 0;
    busy_at_irq = 1'b1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    cyc = 0;
    while (cyc < max_cyc) begin
      axi_bus.awready = 1'b1;
      axi_bus.bvalid = 1'b1;
      axi_bus.wready = wpat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      axi_bus.bresp = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      if (cyc == restart_cyc) begin
        start = 1'b1; dest_addr = 32'h9000_0000; length = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        checkOutput("stall_wvalid", axi_bus.wvalid, 1);
        checkOutput("stall_wdata", axi_bus.wdata, prev_data);
        checkOutput("stall_wlast", axi_bus.wlast, prev_last);
      end
      prev_stall = axi_bus.wvalid && !axi_bus.wready;
      prev_data = axi_bus.wdata;
      prev_last = axi_bus.wlast;
      if (axi_bus.awvalid && axi_bus.wvalid) overlap_cnt++;
      if (axi_bus.awvalid && axi_bus.awready) begin
        aw_addr_q.push_back(axi_bus.awaddr);
        aw_len_q.push_back(axi_bus.awlen);
      end
      if (axi_bus.wvalid && axi_bus.wready) begin
        beat_q.push_back(axi_bus.wdata);
        last_q.push_back(axi_bus.wlast);
      end
      if (axi_bus.bvalid && axi_bus.bready) begin b_cnt++; b_cyc = cyc; end
      if (rd_en) rd_cnt++;
      if (done_irq) begin
        irq_cnt++;
        if (irq_cyc < 0) begin irq_cyc = cyc; busy_at_irq = busy; end
      end
      @(posedge clk); #1;
      cyc++;
      if (irq_cyc >= 0 && cyc > irq_cyc + 2) break;
    end
    start = 1'b0;
    checkOutput("job_done_seen", (irq_cyc >= 0), 1);
    checkOutput("irq_single_cycle", irq_cnt, 1);
    checkOutput("busy_at_irq", busy_at_irq, 0);
    checkOutput("aw_w_overlap", overlap_cnt, 0);
  endtask

  task automatic checkBeats(input string tag, input int src, input int n, input int maxb);
    checkOutput({tag, "_beat_count"}, beat_q.size(), n);
    for (int k = 0; k < n && k < beat_q.size(); k++) begin
      checkOutput({tag, "_wdata"}, beat_q[k], rowBeat(src + k));
      checkOutput({tag, "_wlast"}, last_q[k], (((k + 1) % maxb == 0) || (k == n - 1)));
    end
  endtask

  initial begin
    int beats_seen;
    axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = 2'b00;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] two-row job");
    applyStimulus(40, 32'h8000_0000, 2);
    runJob(100, 1'b0, -1, -1);
    checkOutput("j1_aw_count", aw_addr_q.size(), 1);
    checkOutput("j1_awaddr", aw_addr_q[0], 32'h8000_0000);
    checkOutput("j1_awlen", aw_len_q[0], 1);
    checkBeats("j1", 40, 2, 16);
    checkOutput("j1_irq_after_b", irq_cyc, b_cyc + 1);
    checkOutput("j1_wb_error", wb_error, 0);
    checkOutput("j1_awsize", axi_bus.awsize, 3'd4);
    checkOutput("j1_wstrb", axi_bus.wstrb, 16'hFFFF);

    $display("[TB] twenty rows, two bursts, buffer address wrap, stray start");
    applyStimulus(1020, 32'h8000_0000, 20);
    runJob(300, 1'b0, -1, 4);
    checkOutput("j2_aw_count", aw_addr_q.size(), 2);
    checkOutput("j2_awaddr0", aw_addr_q[0], 32'h8000_0000);
    checkOutput("j2_awlen0", aw_len_q[0], 15);
    checkOutput("j2_awaddr1", aw_addr_q[1], 32'h8000_0100);
    checkOutput("j2_awlen1", aw_len_q[1], 3);
    checkBeats("j2", 1020, 20, 16);
    checkOutput("j2_reads", rd_cnt, 20);

    $display("[TB] near 4 KB page end, unaligned destination");
    applyStimulus(100, 32'h8000_0FE7, 4);
    runJob(200, 1'b0, -1, -1);
`ifdef WRITEBACK_4K_SPLIT_EN
    checkOutput("j3_aw_count", aw_addr_q.size(), 2);
    checkOutput("j3_awaddr0", aw_addr_q[0], 32'h8000_0FE0);
    checkOutput("j3_awlen0", aw_len_q[0], 1);
    checkOutput("j3_awaddr1", aw_addr_q[1], 32'h8000_1000);
    checkOutput("j3_awlen1", aw_len_q[1], 1);
    checkBeats("j3", 100, 4, 2);
`else
    checkOutput("j3_aw_count", aw_addr_q.size(), 1);
    checkOutput("j3_awaddr0", aw_addr_q[0], 32'h8000_0FE0);
    checkOutput("j3_awlen0", aw_len_q[0], 3);
    checkBeats("j3", 100, 4, 16);
`endif

    $display("[TB] wready 1,0,0,1 pattern");
    applyStimulus(500, 32'h8000_2000, 8);
    runJob(300, 1'b1, -1, -1);
    checkOutput("j4_aw_count", aw_addr_q.size(), 1);
    checkOutput("j4_awlen", aw_len_q[0], 7);
    checkBeats("j4", 500, 8, 16);

    $display("[TB] error response on first burst");
    applyStimulus(0, 32'h8000_0000, 20);
    runJob(300, 1'b0, 0, -1);
    checkOutput("j5_aw_count", aw_addr_q.size(), 1);
    checkOutput("j5_beat_count", beat_q.size(), 16);
    checkOutput("j5_wb_error", wb_error, 1);
    applyStimulus(8, 32'h8000_0000, 2);
    checkOutput("j6_wb_error_cleared", wb_error, 0);
    checkOutput("j6_busy", busy, 1);
    runJob(100, 1'b0, -1, -1);
    checkBeats("j6", 8, 2, 16);

    $display("[TB] reset during third beat");
    applyStimulus(200, 32'h8000_3000, 8);
    beats_seen = 0;
    for (int c = 0; c < 100 && beats_seen < 2; c++) begin
      @(negedge clk);
      if (axi_bus.wvalid && axi_bus.wready) beats_seen++;
    end
    checkOutput("j7_reached_beat3", beats_seen, 2);
    @(negedge clk);
    checkOutput("j7_beat3_valid", axi_bus.wvalid, 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    checkZero("midreset");
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    irq_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_irq || busy || axi_bus.awvalid) irq_cnt++;
    end
    checkOutput("j7_quiet_after_reset", irq_cnt, 0);

    $display("[TB] zero-length job");
    applyStimulus(300, 32'h8000_4000, 0);
    runJob(20, 1'b0, -1, -1);
    checkOutput("j8_irq_cycle", irq_cyc, 0);
    checkOutput("j8_aw_count", aw_addr_q.size(), 0);
    checkOutput("j8_beat_count", beat_q.size(), 0);
    checkOutput("j8_b_count", b_cnt, 0);
    checkOutput("j8_reads", rd_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
